// File: rtl/systolic_pkg.sv
// Shared constants and state encoding for the systolic array feeder.
package systolic_pkg;
    localparam int N            = 4;
    localparam int STREAM_STEPS = 2 * N - 1;
    localparam logic LD_SEL_A   = 1'b0;
    localparam logic LD_SEL_B   = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_t;
endpackage

// File: rtl/feeder_bank.sv
// 16-entry operand register file: one synchronous write port, N combinational read ports.
module feeder_bank
    import systolic_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [3:0]           waddr,
    input  logic [DW-1:0]        wdata,
    input  logic [N-1:0][3:0]    raddr,
    output logic [N-1:0][DW-1:0] rdata
);
    logic [N*N-1:0][DW-1:0] mem_q, mem_d;

    always_comb begin
        mem_d = mem_q;
        if (we) mem_d[waddr] = wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) mem_q <= '0;
        else     mem_q <= mem_d;
    end

    always_comb begin
        rdata = '0;
        for (int p = 0; p < N; p++) rdata[p] = mem_q[raddr[p]];
    end
endmodule

// File: rtl/systolic_feeder.sv
// Buffers A/B operands and drives diagonally skewed west/north streams into the 4x4 array.
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DRAIN = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic          ld_sel,
    input  logic [3:0]    ld_addr,
    input  logic [DW-1:0] ld_data,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          arr_clr,
    output logic [DW-1:0] west0,
    output logic [DW-1:0] west1,
    output logic [DW-1:0] west2,
    output logic [DW-1:0] west3,
    output logic [DW-1:0] north0,
    output logic [DW-1:0] north1,
    output logic [DW-1:0] north2,
    output logic [DW-1:0] north3
);
    localparam logic [7:0] STREAM_LAST = 8'(STREAM_STEPS - 1);
    localparam logic [7:0] DRAIN_LAST  = (DRAIN > 0) ? 8'(DRAIN - 1) : 8'd0;

    state_t                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [N-1:0][DW-1:0]   west_q, west_d, north_q, north_d;
    logic [N-1:0][DW-1:0]   a_rd, b_rd;
    logic [N-1:0][3:0]      a_ra, b_ra;
    logic [N-1:0]           w_ok, n_ok;
    logic                   ld_fire;

    assign ld_ready = (state_q == ST_IDLE);
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign arr_clr  = (state_q == ST_CLEAR);
    assign ld_fire  = ld_valid & ld_ready;

    feeder_bank #(.DW(DW)) u_bank_a (
        .clk(clk), .rst(rst), .we(ld_fire & (ld_sel == LD_SEL_A)),
        .waddr(ld_addr), .wdata(ld_data), .raddr(a_ra), .rdata(a_rd)
    );

    feeder_bank #(.DW(DW)) u_bank_b (
        .clk(clk), .rst(rst), .we(ld_fire & (ld_sel == LD_SEL_B)),
        .waddr(ld_addr), .wdata(ld_data), .raddr(b_ra), .rdata(b_rd)
    );

    // cnt is the stream step t in STREAM and the drain cycle index in DRAIN
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE:   if (start) state_d = ST_CLEAR;
            ST_CLEAR: begin
                state_d = ST_STREAM;
                cnt_d   = '0;
            end
            ST_STREAM: begin
                if (cnt_q == STREAM_LAST) begin
                    state_d = (DRAIN == 0) ? ST_DONE : ST_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == DRAIN_LAST) state_d = ST_DONE;
                else                     cnt_d   = cnt_q + 8'd1;
            end
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Skew: row i of A starts i steps late, column j of B starts j steps late.
    // Addresses are formed from the upcoming step so the outputs register in time.
    always_comb begin
        a_ra = '0;
        b_ra = '0;
        w_ok = '0;
        n_ok = '0;
        for (int i = 0; i < N; i++) begin
            w_ok[i] = (cnt_d >= 8'(i)) && (cnt_d <= 8'(i + N - 1));
            n_ok[i] = w_ok[i];
            a_ra[i] = 4'(i * N) + 4'(cnt_d - 8'(i));
            b_ra[i] = 4'((cnt_d - 8'(i)) * 8'(N)) + 4'(i);
        end
    end

    always_comb begin
        west_d  = '0;
        north_d = '0;
        if (state_d == ST_STREAM) begin
            for (int i = 0; i < N; i++) begin
                west_d[i]  = w_ok[i] ? a_rd[i] : '0;
                north_d[i] = n_ok[i] ? b_rd[i] : '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            west_q  <= '0;
            north_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            west_q  <= west_d;
            north_q <= north_d;
        end
    end

    assign west0  = west_q[0];
    assign west1  = west_q[1];
    assign west2  = west_q[2];
    assign west3  = west_q[3];
    assign north0 = north_q[0];
    assign north1 = north_q[1];
    assign north2 = north_q[2];
    assign north3 = north_q[3];
endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: two instances (DRAIN=3 and DRAIN=0) plus a small array model.
module tb_systolic_feeder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        ld_valid = 1'b0;
    logic        ld_sel   = 1'b0;
    logic [3:0]  ld_addr  = '0;
    logic [31:0] ld_data  = '0;
    logic        start0   = 1'b0;
    logic        start1   = 1'b0;

    logic ld_ready0, busy0, done0, clr0;
    logic ld_ready1, busy1, done1, clr1;
    logic [3:0][31:0] w0, n0, w1, n1;

    int total = 0;
    int bad   = 0;

    logic [31:0] ma [16];
    logic [31:0] mb [16];
    logic [31:0] acc [4][4];
    logic [31:0] ha  [4][4];
    logic [31:0] vb  [4][4];
    logic [31:0] ain [4][4];
    logic [31:0] bin [4][4];

    systolic_feeder #(.DW(32), .DRAIN(3)) dut0 (
        .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready0), .ld_sel(ld_sel),
        .ld_addr(ld_addr), .ld_data(ld_data), .start(start0), .busy(busy0), .done(done0),
        .arr_clr(clr0), .west0(w0[0]), .west1(w0[1]), .west2(w0[2]), .west3(w0[3]),
        .north0(n0[0]), .north1(n0[1]), .north2(n0[2]), .north3(n0[3])
    );

    systolic_feeder #(.DW(32), .DRAIN(0)) dut1 (
        .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready1), .ld_sel(ld_sel),
        .ld_addr(ld_addr), .ld_data(ld_data), .start(start1), .busy(busy1), .done(done1),
        .arr_clr(clr1), .west0(w1[0]), .west1(w1[1]), .west2(w1[2]), .west3(w1[3]),
        .north0(n1[0]), .north1(n1[1]), .north2(n1[2]), .north3(n1[3])
    );

    // Output-stationary 4x4 array model fed by dut0, one hop per cycle.
    always_comb begin
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ain[i][j] = (j == 0) ? w0[i] : ha[i][(j + 3) % 4];
                bin[i][j] = (i == 0) ? n0[j] : vb[(i + 3) % 4][j];
            end
    end

    always @(negedge clk or posedge rst) begin
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                if (rst) begin
                    acc[i][j] <= '0;
                    ha[i][j]  <= '0;
                    vb[i][j]  <= '0;
                end else begin
                    acc[i][j] <= clr0 ? 32'd0 : acc[i][j] + ain[i][j] * bin[i][j];
                    ha[i][j]  <= ain[i][j];
                    vb[i][j]  <= bin[i][j];
                end
            end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ld(input logic sel, input int addr, input logic [31:0] data);
        ld_valid = 1'b1;
        ld_sel   = sel;
        ld_addr  = 4'(addr);
        ld_data  = data;
        tick();
        ld_valid = 1'b0;
        if (sel) mb[addr] = data;
        else     ma[addr] = data;
    endtask

    task automatic load_a_b(input logic [31:0] bdiag);
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                ld(1'b0, i * 4 + k, 32'(16 * i + k + 1));
                ld(1'b1, i * 4 + k, (i == k) ? bdiag : 32'd0);
            end
    endtask

    function automatic logic [31:0] expw(input int i, input int t);
        return (t - i >= 0 && t - i <= 3) ? ma[i * 4 + t - i] : 32'd0;
    endfunction

    function automatic logic [31:0] expn(input int j, input int t);
        return (t - j >= 0 && t - j <= 3) ? mb[(t - j) * 4 + j] : 32'd0;
    endfunction

    // One full dut0 run; inj >= 0 drives a load and a start just before stream step inj.
    task automatic run_check(input string tag, input int inj);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        chk({tag, " clr"}, clr0, 1);
        chk({tag, " busy"}, busy0, 1);
        chk({tag, " clr west0"}, w0[0], 0);
        for (int t = 0; t < 7; t++) begin
            if (t == inj) begin
                chk({tag, " ld_ready in stream"}, ld_ready0, 0);
                ld_valid = 1'b1; ld_sel = 1'b0; ld_addr = 4'd5; ld_data = 32'hBEEF;
                start0 = 1'b1;
            end
            tick();
            ld_valid = 1'b0;
            start0   = 1'b0;
            if (t == 0) chk({tag, " clr low"}, clr0, 0);
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("%s t=%0d west%0d", tag, t, i), w0[i], expw(i, t));
                chk($sformatf("%s t=%0d north%0d", tag, t, i), n0[i], expn(i, t));
            end
        end
        for (int d = 0; d < 3; d++) begin
            tick();
            chk($sformatf("%s drain%0d done", tag, d), done0, 0);
            chk($sformatf("%s drain%0d west3", tag, d), w0[3], 0);
        end
        tick();
        chk({tag, " done"}, done0, 1);
        chk({tag, " busy at done"}, busy0, 1);
        tick();
        chk({tag, " done low"}, done0, 0);
        chk({tag, " idle busy"}, busy0, 0);
        chk({tag, " idle ready"}, ld_ready0, 1);
    endtask

    task automatic chk_result(input string tag);
        logic [31:0] e;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                e = '0;
                for (int k = 0; k < 4; k++) e = e + ma[i * 4 + k] * mb[k * 4 + j];
                chk($sformatf("%s result[%0d]", tag, i * 4 + j), acc[i][j], e);
            end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int cnt;
        int seen;
        for (int a = 0; a < 16; a++) begin ma[a] = '0; mb[a] = '0; end
        #12;
        chk("reset ready", ld_ready0, 1);
        chk("reset busy", busy0, 0);
        chk("reset done", done0, 0);
        chk("reset west0", w0[0], 0);
        rst = 1'b0;
        tick();

        // Reset in the middle of a stream
        load_a_b(32'd1);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        tick(); tick(); tick();
        chk("pre-reset west0 t=2", w0[0], 32'd3);
        rst = 1'b1;
        #1;
        chk("midrst busy", busy0, 0);
        chk("midrst ready", ld_ready0, 1);
        chk("midrst clr", clr0, 0);
        chk("midrst west0", w0[0], 0);
        chk("midrst west1", w0[1], 0);
        chk("midrst north0", n0[0], 0);
        #2 rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (done0) seen = 1;
        end
        chk("midrst no done", seen, 0);
        for (int a = 0; a < 16; a++) begin ma[a] = '0; mb[a] = '0; end

        // A[i][k] = 16i+k+1, B = I
        load_a_b(32'd1);
        run_check("identity", -1);
        chk_result("A*I");

        // B = 2I
        for (int i = 0; i < 4; i++) ld(1'b1, i * 5, 32'd2);
        run_check("double", -1);
        chk_result("A*2I");

        // Load and start in the same cycle
        ld_valid = 1'b1; ld_sel = 1'b0; ld_addr = 4'd0; ld_data = 32'hDEAD;
        start0 = 1'b1;
        tick();
        ld_valid = 1'b0;
        start0   = 1'b0;
        ma[0] = 32'hDEAD;
        tick();
        chk("same-cycle west0", w0[0], 32'hDEAD);
        cnt = 0;
        while (!done0 && cnt < 20) begin tick(); cnt++; end
        chk("same-cycle done", done0, 1);
        tick();
        ld(1'b0, 0, 32'd1);

        // Load and start during a stream are ignored; rerun reproduces the stream
        run_check("inject", 3);
        run_check("rerun", -1);
        chk_result("rerun A*2I");

        // DRAIN=0 instance, back-to-back runs
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("d0 busy", busy1, 1);
        chk("d0 clr", clr1, 1);
        cnt = 0;
        while (!done1 && cnt < 20) begin tick(); cnt++; end
        chk("d0 done latency", cnt, 8);
        tick();
        chk("d0 idle", busy1, 0);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("d0 b2b busy", busy1, 1);
        chk("d0 b2b clr", clr1, 1);
        tick();
        chk("d0 b2b west0", w1[0], 32'd1);
        cnt = 1;
        while (!done1 && cnt < 20) begin tick(); cnt++; end
        chk("d0 b2b done latency", cnt, 8);
        tick();
        chk("d0 b2b done low", done1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
